// File: rtl/alu_regfile.sv
// Eight-entry register file with two combinational read ports and one write port,
// feeding a small combinational ALU with a zero-extended 8-bit immediate.
module alu_regfile #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_BITS-1:0] address_a,
   input  logic [ADDR_BITS-1:0] address_b,
   input  logic                 write_enable,
   input  logic [WIDTH-1:0]     write_data,
   input  logic [3:0]           opcode,
   input  logic [7:0]           immediate,
   output logic [WIDTH-1:0]     data_a,
   output logic [WIDTH-1:0]     data_b,
   output logic [WIDTH-1:0]     alu_result,
   output logic                 alu_zero
);

   localparam int unsigned NREGS = 2 ** ADDR_BITS;

   typedef enum logic [3:0] {
      OP_LOAD = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SUB  = 4'b0011,
      OP_ADDI = 4'b1010,
      OP_SUBI = 4'b1011,
      OP_MOV  = 4'b1110
   } op_t;

   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] imm_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_enable) begin
         regs[address_a] <= write_data;
      end
   end

   // Reads are unregistered, so a write only becomes visible after its edge.
   assign data_a  = regs[address_a];
   assign data_b  = regs[address_b];
   assign imm_ext = WIDTH'(immediate);

   always_comb begin
      alu_result = '0;
      case (opcode)
         OP_ADD:  alu_result = data_a + data_b;
         OP_ADDI: alu_result = data_a + imm_ext;
         OP_SUB:  alu_result = data_a - data_b;
         OP_SUBI: alu_result = data_a - imm_ext;
         OP_LOAD: alu_result = imm_ext;
         OP_MOV:  alu_result = data_b;
         default: alu_result = '0;
      endcase
   end

   assign alu_zero = (alu_result == '0);

endmodule

// File: tb/tb_alu_regfile.sv
// Randomized and directed bench for alu_regfile against an array-based reference model.
module tb_alu_regfile;

   localparam int WIDTH     = 16;
   localparam int ADDR_BITS = 3;
   localparam longint MASK  = (64'd1 << WIDTH) - 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [ADDR_BITS-1:0] address_a, address_b;
   logic                 write_enable;
   logic [WIDTH-1:0]     write_data;
   logic [3:0]           opcode;
   logic [7:0]           immediate;
   logic [WIDTH-1:0]     data_a, data_b, alu_result;
   logic                 alu_zero;

   int n_checks = 0;
   int n_fail   = 0;
   longint mregs [8];

   alu_regfile #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
      .clk(clk), .rst(rst), .address_a(address_a), .address_b(address_b),
      .write_enable(write_enable), .write_data(write_data), .opcode(opcode),
      .immediate(immediate), .data_a(data_a), .data_b(data_b),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic longint model_alu(input int op, input longint a, input longint b, input longint imm);
      case (op)
         2:       return (a + b) & MASK;
         10:      return (a + imm) & MASK;
         3:       return (a - b) & MASK;
         11:      return (a - imm) & MASK;
         1:       return imm;
         14:      return b;
         default: return 0;
      endcase
   endfunction

   task automatic check_all(input string tag);
      longint a, b, r;
      a = mregs[address_a];
      b = mregs[address_b];
      r = model_alu(int'(opcode), a, b, longint'(immediate));
      check({tag, ".data_a"}, 64'(data_a), 64'(a));
      check({tag, ".data_b"}, 64'(data_b), 64'(b));
      check({tag, ".result"}, 64'(alu_result), 64'(r));
      check({tag, ".zero"}, 64'(alu_zero), 64'(r == 0));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mregs[i] = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (write_enable && !rst) mregs[address_a] = longint'(write_data);
      #1;
   endtask

   task automatic wr(input int a, input int d);
      address_a    = ADDR_BITS'(a);
      write_data   = WIDTH'(d);
      write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
   endtask

   task automatic sel(input int a, input int b, input int op, input int imm);
      address_a = ADDR_BITS'(a);
      address_b = ADDR_BITS'(b);
      opcode    = 4'(op);
      immediate = 8'(imm);
      #1;
   endtask

   initial begin
      rst = 1'b1; address_a = '0; address_b = '0; write_enable = 1'b1;
      write_data = 16'hDEAD; opcode = 4'b0010; immediate = '0;
      model_reset();
      #12;
      check("reset.data_a", 64'(data_a), 64'h0);
      check("reset.data_b", 64'(data_b), 64'h0);
      check("reset.result", 64'(alu_result), 64'h0);
      check("reset.zero", 64'(alu_zero), 64'h1);
      @(posedge clk); #1;
      check("reset_blocks_write", 64'(data_a), 64'h0);
      write_enable = 1'b0;
      rst = 1'b0;
      tick();

      // Asynchronous clear mid-cycle
      wr(3, 16'h1234);
      sel(3, 3, 2, 0);
      check("pre_reset.reg3", 64'(data_a), 64'h1234);
      rst = 1'b1; #1;
      model_reset();
      check("async_reset.data_a", 64'(data_a), 64'h0);
      check("async_reset.zero", 64'(alu_zero), 64'h1);
      #1 rst = 1'b0;
      tick();

      wr(2, 5); wr(5, 3);
      sel(2, 5, 4'b0010, 0); check("add", 64'(alu_result), 64'h0008);
      sel(2, 5, 4'b0011, 0); check("sub", 64'(alu_result), 64'h0002);
      sel(2, 5, 4'b1110, 0); check("mov", 64'(alu_result), 64'h0003);

      wr(1, 16'h00FF);
      sel(1, 0, 4'b1010, 8'h01); check("addi", 64'(alu_result), 64'h0100);
      sel(1, 0, 4'b1011, 8'hFF); check("subi", 64'(alu_result), 64'h0000);
      check("subi.zero", 64'(alu_zero), 64'h1);
      sel(1, 0, 4'b0001, 8'hA5); check("load", 64'(alu_result), 64'h00A5);

      wr(0, 16'hFFFF); wr(1, 16'h0001);
      sel(0, 1, 4'b0010, 0); check("wrap_add", 64'(alu_result), 64'h0000);
      check("wrap_add.zero", 64'(alu_zero), 64'h1);
      sel(1, 0, 4'b0011, 0); check("wrap_sub", 64'(alu_result), 64'h0002);

      wr(4, 16'h0777);
      address_a = 3'd4; write_data = 16'h0BEE; write_enable = 1'b1; #1;
      check("no_bypass.old", 64'(data_a), 64'h0777);
      tick();
      check("no_bypass.new", 64'(data_a), 64'h0BEE);
      write_enable = 1'b0; write_data = 16'h1111;
      tick();
      check("write_disable", 64'(data_a), 64'h0BEE);

      sel(4, 5, 4'b1000, 8'h33);
      check("undef_op", 64'(alu_result), 64'h0);
      check("undef_op.zero", 64'(alu_zero), 64'h1);
      sel(4, 5, 4'b1111, 8'h33); check("out_op", 64'(alu_result), 64'h0);

      for (int i = 0; i < 300; i++) begin
         address_a    = ADDR_BITS'($urandom_range(0, 7));
         address_b    = ADDR_BITS'($urandom_range(0, 7));
         opcode       = 4'($urandom_range(0, 15));
         immediate    = 8'($urandom);
         write_data   = ($urandom_range(0, 9) == 0) ? 16'hFFFF : WIDTH'($urandom);
         write_enable = 1'($urandom_range(0, 1));
         #1;
         check_all("rand");
         if ($urandom_range(0, 24) == 0) begin
            rst = 1'b1; #1;
            model_reset();
            check_all("rand_rst");
            rst = 1'b0;
         end
         tick();
         check_all("rand_post");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
